// File: rtl/expo_arbiter.sv
// expo_arbiter: two-requester round-robin front end for one shared
// exponentiation engine. A granted request has its operands latched and is
// sequenced through engine clear, start strobe and wait-for-completion. The
// result is then returned on that requester's z register with a done pulse,
// or the operation is aborted with an err pulse after TIMEOUT wait cycles.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req0/req1           level-held operation requests
//   x0,y0 / x1,y1       per-requester operands
//   z0/z1               per-requester result registers
//   done0/done1         one-cycle result-valid pulses
//   err0/err1           one-cycle timeout-abort pulses
//   busy                high whenever the FSM is not IDLE
//   eng_x, eng_y        latched operands to the engine
//   eng_rst, eng_start  engine clear / start strobes
//   eng_z, eng_done     engine result and completion level
module expo_arbiter #(
    parameter int unsigned W       = 192,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic [W-1:0] z0,
    output logic [W-1:0] z1,
    output logic         done0,
    output logic         done1,
    output logic         err0,
    output logic         err1,
    output logic         busy,
    output logic [W-1:0] eng_x,
    output logic [W-1:0] eng_y,
    output logic         eng_rst,
    output logic         eng_start,
    input  logic [W-1:0] eng_z,
    input  logic         eng_done
);
    typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, RESP} state_t;

    state_t       state_q;
    logic         last_grant_q;
    logic         grant_q;
    logic         done_q;
    logic [15:0]  cnt_q;
    logic [15:0]  cnt_d;
    logic         grant_d;
    logic         complete_d;
    logic [W-1:0] z0_q, z1_q, eng_x_q, eng_y_q;
    logic         done0_q, done1_q, err0_q, err1_q;
    logic         busy_q, eng_rst_q, eng_start_q;

    always_comb begin
        // A lone request wins; on a tie the requester other than last_grant wins.
        grant_d    = (req0 && req1) ? ~last_grant_q : req1;
        // Only a fresh rising edge of eng_done counts, so a level left high
        // from an earlier operation cannot complete this one.
        complete_d = eng_done & ~done_q;
        cnt_d      = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            z0_q         <= '0;
            z1_q         <= '0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            busy_q       <= 1'b0;
            eng_rst_q    <= 1'b0;
            eng_start_q  <= 1'b0;
        end else begin
            done_q      <= eng_done;
            eng_rst_q   <= 1'b0;
            eng_start_q <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        eng_x_q      <= grant_d ? x1 : x0;
                        eng_y_q      <= grant_d ? y1 : y0;
                        eng_rst_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= CLEAR;
                    end
                end
                CLEAR: begin
                    eng_start_q <= 1'b1;
                    state_q     <= LAUNCH;
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    // Completion is checked first so it wins a same-cycle timeout.
                    if (complete_d) begin
                        if (grant_q) begin
                            z1_q    <= eng_z;
                            done1_q <= 1'b1;
                        end else begin
                            z0_q    <= eng_z;
                            done0_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else if (cnt_d == TIMEOUT) begin
                        err0_q  <= ~grant_q;
                        err1_q  <= grant_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign z0        = z0_q;
    assign z1        = z1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign busy      = busy_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;
    assign eng_rst   = eng_rst_q;
    assign eng_start = eng_start_q;
endmodule
